// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with NZCV flag generation.
// Optional sticky overflow flag is built only when EXMEM_STICKY_V_EN is defined;
// otherwise sticky_v is tied low and clear_sticky is ignored.
module ex_mem_stage #(
  parameter int unsigned data_width     = 32,
  parameter int unsigned reg_addr_width = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [data_width-1:0]     ex_a,
  input  logic [data_width-1:0]     ex_b,
  input  logic [3:0]                ex_aluctrl,
  input  logic [data_width-1:0]     ex_alu_z,
  input  logic                      ex_overflow,
  input  logic                      ex_set_flags,
  input  logic [data_width-1:0]     ex_store_data,
  input  logic [reg_addr_width-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      clear_sticky,
  output logic                      mem_valid,
  output logic [data_width-1:0]     mem_alu_z,
  output logic [data_width-1:0]     mem_store_data,
  output logic [reg_addr_width-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic [3:0]                flags,
  output logic                      sticky_v
);

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  logic                      valid_q, valid_d;
  logic [data_width-1:0]     alu_z_q, alu_z_d;
  logic [data_width-1:0]     store_data_q, store_data_d;
  logic [reg_addr_width-1:0] rd_q, rd_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [3:0]                flags_q, flags_d;
  logic                      flag_upd;
  logic [data_width:0]       add_sum;

  // Unsigned sum one bit wider than the datapath; its MSB is the ADD carry-out.
  assign add_sum = {1'b0, ex_a} + {1'b0, ex_b};

  // Next-state: flush makes a bubble, stall holds, otherwise capture EX.
  always_comb begin
    valid_d      = valid_q;
    alu_z_d      = alu_z_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    flags_d      = flags_q;
    flag_upd     = 1'b0;
    if (flush) begin
      valid_d      = 1'b0;
      alu_z_d      = '0;
      store_data_d = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
    end else if (!stall) begin
      valid_d      = ex_valid;
      alu_z_d      = ex_alu_z;
      store_data_d = ex_store_data;
      rd_d         = ex_rd;
      reg_write_d  = ex_reg_write & ex_valid;
      mem_read_d   = ex_mem_read & ex_valid;
      mem_write_d  = ex_mem_write & ex_valid;
      if (ex_valid && ex_set_flags) begin
        flag_upd   = 1'b1;
        flags_d[3] = ex_alu_z[data_width-1];
        flags_d[2] = (ex_alu_z == '0);
        case (ex_aluctrl)
          ALU_ADD: begin
            flags_d[1] = add_sum[data_width];
            flags_d[0] = ex_overflow;
          end
          ALU_SUB: begin
            flags_d[1] = (ex_a >= ex_b);
            flags_d[0] = ex_overflow;
          end
          default: ;
        endcase
      end
    end
  end

  // Pipeline and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_z_q      <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      flags_q      <= 4'b0000;
    end else begin
      valid_q      <= valid_d;
      alu_z_q      <= alu_z_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      flags_q      <= flags_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_z      = alu_z_q;
  assign mem_store_data = store_data_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign flags          = flags_q;

`ifdef EXMEM_STICKY_V_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: clear is honoured even under stall; a same-cycle set wins.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_sticky) sticky_d = 1'b0;
    if (flag_upd && flags_d[0]) sticky_d = 1'b1;
  end

  // Sticky register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = clear_sticky ^ flag_upd;
  assign sticky_v      = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: behavioural model compared every cycle, plus directed literal checks.
module tb_ex_mem_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          reset, stall, flush, ex_valid, ex_overflow, ex_set_flags;
  logic [DW-1:0] ex_a, ex_b, ex_alu_z, ex_store_data;
  logic [3:0]    ex_aluctrl;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, clear_sticky;
  logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, sticky_v;
  logic [DW-1:0] mem_alu_z, mem_store_data;
  logic [RW-1:0] mem_rd;
  logic [3:0]    flags;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.data_width(DW), .reg_addr_width(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_aluctrl(ex_aluctrl), .ex_alu_z(ex_alu_z),
    .ex_overflow(ex_overflow), .ex_set_flags(ex_set_flags), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .clear_sticky(clear_sticky),
    .mem_valid(mem_valid), .mem_alu_z(mem_alu_z), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .flags(flags), .sticky_v(sticky_v)
  );

  always #5 clk = ~clk;

  // Model state (expected outputs).
  bit          m_valid, m_rw, m_mr, m_mw, m_sticky;
  bit [DW-1:0] m_z, m_sd;
  bit [RW-1:0] m_rd;
  bit          m_n, m_zf, m_c, m_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model of one clock edge, using the inputs as they stand at the edge.
  task automatic model_step();
    longint unsigned ua, ub;
    bit updated;
    updated = 0;
    ua = 64'(ex_a);
    ub = 64'(ex_b);
    if (reset) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_z = 0; m_sd = 0; m_rd = 0;
      m_n = 0; m_zf = 0; m_c = 0; m_v = 0; m_sticky = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_z = 0; m_sd = 0; m_rd = 0;
      end else if (!stall) begin
        m_valid = ex_valid;
        m_z  = ex_alu_z;
        m_sd = ex_store_data;
        m_rd = ex_rd;
        m_rw = ex_valid && ex_reg_write;
        m_mr = ex_valid && ex_mem_read;
        m_mw = ex_valid && ex_mem_write;
        if (ex_valid && ex_set_flags) begin
          updated = 1;
          m_n  = ex_alu_z[DW-1];
          m_zf = (ex_alu_z == 0);
          if (ex_aluctrl == 4'd1) begin
            m_c = (ua + ub) >= (64'd1 << DW);
            m_v = ex_overflow;
          end else if (ex_aluctrl == 4'd2) begin
            m_c = !(ua < ub);
            m_v = ex_overflow;
          end
        end
      end
`ifdef EXMEM_STICKY_V_EN
      if (updated && m_v) m_sticky = 1;
      else if (clear_sticky) m_sticky = 0;
`endif
    end
  endtask

  // Compare process: every cycle, 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("mem_valid", 64'(mem_valid), 64'(m_valid));
      chk("mem_alu_z", 64'(mem_alu_z), 64'(m_z));
      chk("mem_store_data", 64'(mem_store_data), 64'(m_sd));
      chk("mem_rd", 64'(mem_rd), 64'(m_rd));
      chk("mem_reg_write", 64'(mem_reg_write), 64'(m_rw));
      chk("mem_mem_read", 64'(mem_mem_read), 64'(m_mr));
      chk("mem_mem_write", 64'(mem_mem_write), 64'(m_mw));
      chk("flags", 64'(flags), 64'({m_n, m_zf, m_c, m_v}));
      chk("sticky_v", 64'(sticky_v), 64'(m_sticky));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; ex_a = 0; ex_b = 0; ex_aluctrl = 0;
    ex_alu_z = 0; ex_overflow = 0; ex_set_flags = 0; ex_store_data = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; clear_sticky = 0;
  endtask

  task automatic op(input logic [3:0] ctl, input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input logic [DW-1:0] z, input logic ovf, input logic sf);
    ex_valid = 1; ex_aluctrl = ctl; ex_a = a; ex_b = b; ex_alu_z = z;
    ex_overflow = ovf; ex_set_flags = sf;
  endtask

  task automatic chk_sticky_lit(input string name, input logic exp);
`ifdef EXMEM_STICKY_V_EN
    chk(name, 64'(sticky_v), 64'(exp));
`else
    chk(name, 64'(sticky_v), 64'(1'b0));
`endif
  endtask

  logic [DW-1:0] held_z;

  initial begin
    idle();
    reset = 1;
    step(); step();
    chk("lit_reset_flags", 64'(flags), 64'(4'b0000));
    chk("lit_reset_valid", 64'(mem_valid), 64'(1'b0));
    reset = 0;

    // Overflowing ADD
    op(4'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1);
    ex_rd = 4'd3; ex_reg_write = 1; ex_store_data = 32'h1234;
    step();
    chk("lit_add_ovf_flags", 64'(flags), 64'(4'b1001));
    chk("lit_add_ovf_z", 64'(mem_alu_z), 64'(32'h8000_0000));
    chk("lit_add_ovf_rd", 64'(mem_rd), 64'(4'd3));
    chk_sticky_lit("lit_sticky_set", 1'b1);

    idle(); op(4'd2, 32'd5, 32'd5, 32'd0, 0, 1);
    step();
    chk("lit_sub_eq_flags", 64'(flags), 64'(4'b0110));
    chk_sticky_lit("lit_sticky_hold", 1'b1);

    idle(); op(4'd4, 32'h1, 32'h2, 32'hF000_0000, 0, 1);
    step();
    chk("lit_and_flags", 64'(flags), 64'(4'b1010));

    idle(); op(4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0);
    step();
    chk("lit_nosf_flags", 64'(flags), 64'(4'b1010));
    chk("lit_nosf_z", 64'(mem_alu_z), 64'(32'h0));
    chk("lit_nosf_valid", 64'(mem_valid), 64'(1'b1));

    idle(); op(4'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
    step();
    chk("lit_add_carry_flags", 64'(flags), 64'(4'b0110));
    chk_sticky_lit("lit_sticky_keep", 1'b1);

    // Invalid slot with write controls, plus sticky clear
    idle(); ex_reg_write = 1; ex_mem_write = 1; ex_mem_read = 1; ex_set_flags = 1;
    ex_alu_z = 32'hDEAD; clear_sticky = 1;
    step();
    chk("lit_inv_rw", 64'(mem_reg_write), 64'(1'b0));
    chk("lit_inv_mw", 64'(mem_mem_write), 64'(1'b0));
    chk("lit_inv_flags", 64'(flags), 64'(4'b0110));
    chk_sticky_lit("lit_sticky_clear", 1'b0);

    // Overflow and clear together: set wins
    idle(); op(4'd1, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1); clear_sticky = 1;
    step();
    chk("lit_add_wrap_flags", 64'(flags), 64'(4'b0111));
    chk_sticky_lit("lit_sticky_set_wins", 1'b1);

    // NOP with set_flags: N=0 Z=1, C/V hold
    idle(); op(4'd0, 32'h5, 32'h6, 32'h0, 0, 1);
    step();
    chk("lit_nop_flags", 64'(flags), 64'(4'b0111));

    idle(); op(4'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1);
    step();
    chk("lit_sub_borrow_flags", 64'(flags), 64'(4'b1000));

    // Load valid instruction, then stall three cycles with changing inputs
    idle(); op(4'd1, 32'h10, 32'h1, 32'h11, 0, 0);
    ex_rd = 4'd9; ex_reg_write = 1; ex_mem_read = 1; ex_store_data = 32'hCAFE;
    step();
    held_z = mem_alu_z;
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; op(4'd2, 32'd1, 32'd2, 32'($urandom), 1, 1);
      ex_rd = 4'(i); ex_mem_write = 1;
      clear_sticky = (i == 1);
      step();
    end
    chk("lit_stall_z", 64'(mem_alu_z), 64'(32'h11));
    chk("lit_stall_z_const", 64'(mem_alu_z), 64'(held_z));
    chk("lit_stall_rd", 64'(mem_rd), 64'(4'd9));
    chk("lit_stall_flags", 64'(flags), 64'(4'b1000));
    chk_sticky_lit("lit_stall_clear", 1'b0);

    // Stall and flush together with a flag-setting instruction present
    idle(); stall = 1; flush = 1; op(4'd1, 32'h1, 32'h1, 32'h2, 1, 1); ex_reg_write = 1;
    step();
    chk("lit_flush_valid", 64'(mem_valid), 64'(1'b0));
    chk("lit_flush_z", 64'(mem_alu_z), 64'(32'h0));
    chk("lit_flush_flags", 64'(flags), 64'(4'b1000));

    // Reset during a stall holding valid data
    idle(); op(4'd2, 32'd9, 32'd1, 32'd8, 0, 1); ex_rd = 4'd7; ex_mem_write = 1;
    ex_store_data = 32'h55;
    step();
    idle(); stall = 1; reset = 1;
    step();
    chk("lit_rst_mid_valid", 64'(mem_valid), 64'(1'b0));
    chk("lit_rst_mid_flags", 64'(flags), 64'(4'b0000));
    chk("lit_rst_mid_sd", 64'(mem_store_data), 64'(32'h0));

    // First capture after reset release
    idle(); reset = 0; op(4'd1, 32'h2, 32'h3, 32'h5, 0, 1); ex_rd = 4'd1;
    step();
    chk("lit_post_rst_z", 64'(mem_alu_z), 64'(32'h5));
    chk("lit_post_rst_flags", 64'(flags), 64'(4'b0000));

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline register with architectural flag generation for the ARM-32 pipeline. Sits directly downstream of the 32-bit ALU: captures the ALU result, overflow and operands each cycle, and derives and holds the NZCV condition flags. Forwards the result and memory/writeback controls to the MEM stage, with stall, flush and bubble handling.

## Interface
Parameters:
- `data_width`, 32, datapath width; must match the ALU.
- `reg_addr_width`, 4, destination register index width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all state this cycle.
- `flush`  in  1  insert bubble this cycle.
- `ex_valid`  in  1  EX slot holds a real instruction.
- `ex_a`, `ex_b`  in  data_width  ALU operands, same values presented to the ALU.
- `ex_aluctrl`  in  4  ALU op code (0001 ADD, 0010 SUB relevant here).
- `ex_alu_z`  in  data_width  ALU result.
- `ex_overflow`  in  1  ALU signed-overflow output.
- `ex_set_flags`  in  1  instruction updates NZCV (S bit).
- `ex_store_data`  in  data_width  store data for MEM.
- `ex_rd`  in  reg_addr_width  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  in  1 each  control bits.
- `clear_sticky`  in  1  clear sticky overflow (see Configuration).
- `mem_valid`  out  1  MEM slot valid.
- `mem_alu_z`, `mem_store_data`  out  data_width  registered result and store data.
- `mem_rd`  out  reg_addr_width  registered destination.
- `mem_reg_write`, `mem_mem_read`, `mem_mem_write`  out  1 each  registered controls.
- `flags`  out  4  NZCV as {N,Z,C,V}, registered.
- `sticky_v`  out  1  sticky overflow flag.

## Operation
- Priority each edge: reset > flush > stall > capture.
- Reset: every output and internal register is 0, including `flags` = 4'b0000 and `sticky_v` = 0.
- Flush: `mem_valid`, `mem_reg_write`, `mem_mem_read`, `mem_mem_write` = 0. `mem_alu_z`, `mem_store_data` and `mem_rd` = 0. Flags unchanged.
- Stall without flush: all registers hold, including flags.
- Capture: all `mem_*` data take EX values. `mem_valid` = `ex_valid`. Each control bit = EX bit AND `ex_valid`, so an invalid slot never writes.
- Flag update occurs only on capture with `ex_valid` & `ex_set_flags`:
  - N = `ex_alu_z[data_width-1]`.
  - Z = (`ex_alu_z` == 0).
  - C: ADD → carry-out of the (data_width+1)-bit unsigned sum `ex_a`+`ex_b`. SUB → NOT borrow, i.e. 1 when `ex_a` ≥ `ex_b` unsigned. Any other op → C holds.
  - V: ADD/SUB → `ex_overflow`. Any other op → V holds.
- NOP op with set_flags: N=0, Z=1, C and V hold.

## Timing
- Latency: 1 cycle from EX inputs to `mem_*` and `flags`. No combinational path from inputs to outputs.
- Flags written by instruction i are visible on `flags` in the cycle instruction i is in MEM.
- Stall and flush asserted together: flush wins, and the slot becomes a bubble.
- A reset asserted mid-stream discards the in-flight instruction. First capture occurs on the first edge with reset low.
- Back-to-back flag-setting instructions: each updates in turn, and the last one wins.

## Configuration
- `EXMEM_STICKY_V_EN` defined:
  - `sticky_v` sets on any flag update where the new V = 1.
  - It stays set until `reset`, or until `clear_sticky` is sampled high.
  - Set and clear in the same cycle: set wins.
  - Stall does not block `clear_sticky`.
- Undefined: `sticky_v` is tied to 0, `clear_sticky` is ignored, and no sticky register is built.

## Test plan
- Reset, then capture ADD with a=0x7FFFFFFF, b=1, z=0x80000000, ovf=1, set_flags=1 → next cycle flags=4'b1001, mem_alu_z=0x80000000.
- SUB with a=5, b=5, z=0, set_flags=1 → flags=4'b0110. Then AND with z=0xF0000000, set_flags=1 → flags=4'b1010 (C and V held).
- ADD with a=0xFFFFFFFF, b=1, z=0, ovf=0, set_flags=0 → flags unchanged, and mem_alu_z=0, mem_valid=1.
- Capture with ex_valid=0 while ex_reg_write=1 and ex_mem_write=1 → mem_reg_write=0, mem_mem_write=0. Stall for 3 cycles → outputs constant. Stall+flush together → bubble.
- Assert reset during a stall holding valid data → next cycle all outputs 0, flags=0.
- With `EXMEM_STICKY_V_EN`: overflowing ADD sets sticky_v=1. A following non-overflow ADD keeps sticky_v=1. clear_sticky=1 → sticky_v=0 next cycle. Clear in the same cycle as an overflowing update → sticky_v=1.
